rr_arbiter4: RTL and testbench

//  Round-robin arbiter that drives the 2-bit select of the 4:1 N-bit datapath mux.

---
 rtl/rr_arbiter4.sv | 112 +++++++++++
 tb/tb_rr_arbiter4.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin select controller for a 4:1 datapath mux.
// A winner holds the grant for up to BURST accepted words, then priority rotates.
module rr_arbiter4 #(
  parameter int unsigned BURST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] select,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic       burst_last
);

  localparam int unsigned CW = ($clog2(BURST + 1) < 1) ? 1 : $clog2(BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_d;
  logic [3:0]    grant_d;

  logic          xfer;
  logic [CW:0]   cnt_inc;
  logic          cnt_more;
  logic          cnt_last;
  logic [2:0]    pick_idle;
  logic [2:0]    pick_rot;

  // First set request after pointer p, wrapping; {found, index}
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign xfer       = out_valid & out_ready;
  assign cnt_inc    = (CW+1)'(cnt_q) + (CW+1)'(1);
  assign cnt_more   = cnt_inc < (CW+1)'(BURST);
  assign cnt_last   = cnt_inc == (CW+1)'(BURST);
  assign pick_idle  = rr_pick(ptr_q, req);
  assign pick_rot   = rr_pick(sel_q, req);
  assign burst_last = out_valid & (cnt_last | ~req[sel_q]);

  // Next-state: grant, burst counting, rotation and abandon handling
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          sel_d   = pick_idle[1:0];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (cnt_more && req[sel_q]) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            ptr_d = sel_q;
            cnt_d = '0;
            if (pick_rot[2]) sel_d = pick_rot[1:0];
            else             state_d = IDLE;
          end
        end else if (!req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == GRANT);
    grant_d = valid_d ? (4'b0001 << sel_d) : 4'b0000;
  end

  // State and registered outputs; pointer resets to 3 so ch0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      grant     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      out_valid <= valid_d;
      grant     <= grant_d;
    end
  end

  assign select = sel_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: scoreboard bench for rr_arbiter4 at BURST=1 (dut a) and BURST=2 (dut b).
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel_a, sel_b;
  logic [3:0] gnt_a, gnt_b;
  logic       val_a, val_b;
  logic       bl_a, bl_b;

  rr_arbiter4 #(.BURST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .select(sel_a), .grant(gnt_a), .out_valid(val_a), .burst_last(bl_a)
  );

  rr_arbiter4 #(.BURST(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .select(sel_b), .grant(gnt_b), .out_valid(val_b), .burst_last(bl_b)
  );

  typedef struct {
    int         id;
    string      name;
    logic       v;
    logic [1:0] sel;
    logic       selchk;
    logic       bl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop every expectation queued for this cycle and compare
  always @(negedge clk) begin
    exp_t       e;
    logic       av;
    logic [1:0] asel;
    logic [3:0] ag;
    logic [3:0] eg;
    logic       abl;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.id == 0) begin av = val_a; asel = sel_a; ag = gnt_a; abl = bl_a; end
      else           begin av = val_b; asel = sel_b; ag = gnt_b; abl = bl_b; end
      eg = e.v ? (4'b0001 << e.sel) : 4'b0000;
      checks++;
      if (av === e.v) passed++;
      else $display("FAIL %s dut%0d out_valid: got %b expected %b", e.name, e.id, av, e.v);
      checks++;
      if (ag === eg) passed++;
      else $display("FAIL %s dut%0d grant: got %b expected %b", e.name, e.id, ag, eg);
      checks++;
      if (abl === e.bl) passed++;
      else $display("FAIL %s dut%0d burst_last: got %b expected %b", e.name, e.id, abl, e.bl);
      if (e.selchk) begin
        checks++;
        if (asel === e.sel) passed++;
        else $display("FAIL %s dut%0d select: got %0d expected %0d", e.name, e.id, asel, e.sel);
      end
    end
  end

  task automatic push(input int id, input string nm, input logic v,
                      input logic [1:0] s, input logic chk_sel, input logic bl);
    exp_t e;
    e.id = id; e.name = nm; e.v = v; e.sel = s; e.selchk = chk_sel; e.bl = bl;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs, queue what each checked dut should show, advance
  task automatic cyc(input string nm, input logic [3:0] r, input logic rd,
                     input logic ca, input logic va, input logic [1:0] sa, input logic bla,
                     input logic cb, input logic vb, input logic [1:0] sb, input logic blb);
    req       = r;
    out_ready = rd;
    if (ca) push(0, nm, va, sa, va, bla);
    if (cb) push(1, nm, vb, sb, vb, blb);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any edge
  task automatic rst_pulse(input string nm);
    #1;
    rst_n = 1'b0;
    push(0, nm, 1'b0, 2'd0, 1'b1, 1'b0);
    push(1, nm, 1'b0, 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    push(0, "por", 1'b0, 2'd0, 1'b1, 1'b0);
    push(1, "por", 1'b0, 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BURST=1 strict rotation 0,1,2,3,0,1
    cyc("b1_rot", 4'b1111, 1'b1, 1, 0, 2'd0, 0,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd0, 1,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd1, 1,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd2, 1,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd3, 1,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd0, 1,  0, 0, 2'd0, 0);
    cyc("b1_rot", 4'b1111, 1'b1, 1, 1, 2'd1, 1,  0, 0, 2'd0, 0);
    rst_pulse("rst_mid_grant");

    // BURST=2 pairs 0,0,1,1,2,2,3,3; ch0 wins first after reset
    cyc("b2_rot", 4'b1111, 1'b1, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);
    cyc("b2_rot", 4'b1111, 1'b1, 1, 1, 2'd0, 1,  1, 1, 2'd0, 0);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd0, 1);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd1, 0);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd1, 1);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd2, 0);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd2, 1);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd3, 0);
    cyc("b2_rot", 4'b1111, 1'b1, 0, 0, 2'd0, 0,  1, 1, 2'd3, 1);
    rst_pulse("rst2");

    // Lone requester ch2: granted after one cycle, re-granted with no bubble
    cyc("lone2", 4'b0100, 1'b1, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);
    cyc("lone2", 4'b0100, 1'b1, 1, 1, 2'd2, 1,  1, 1, 2'd2, 0);
    cyc("lone2", 4'b0100, 1'b1, 1, 1, 2'd2, 1,  1, 1, 2'd2, 1);
    cyc("lone2", 4'b0100, 1'b1, 1, 1, 2'd2, 1,  1, 1, 2'd2, 0);
    rst_pulse("rst3");

    // Backpressure: ch0 held for 5 cycles, count stays 0, then sequence resumes
    cyc("bp", 4'b1111, 1'b0, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);
    for (int i = 0; i < 5; i++)
      cyc("bp_hold", 4'b1111, 1'b0, 1, 1, 2'd0, 1,  1, 1, 2'd0, 0);
    cyc("bp_go", 4'b1111, 1'b1, 1, 1, 2'd0, 1,  1, 1, 2'd0, 0);
    cyc("bp_go", 4'b1111, 1'b1, 1, 1, 2'd1, 1,  1, 1, 2'd0, 1);
    cyc("bp_go", 4'b1111, 1'b1, 1, 1, 2'd2, 1,  1, 1, 2'd1, 0);
    rst_pulse("rst4");

    // Abandon: ch1 granted, stalled, drops request; ch3 wins after the IDLE cycle
    cyc("abandon", 4'b0010, 1'b0, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);
    cyc("abandon", 4'b1000, 1'b0, 1, 1, 2'd1, 1,  1, 1, 2'd1, 1);
    cyc("abandon", 4'b1000, 1'b0, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);
    cyc("abandon", 4'b1000, 1'b0, 1, 1, 2'd3, 1,  1, 1, 2'd3, 0);
    // All requests drop during an accepted transfer: back to IDLE
    cyc("drain", 4'b0000, 1'b1, 1, 1, 2'd3, 1,  1, 1, 2'd3, 1);
    cyc("drain", 4'b0000, 1'b1, 1, 0, 2'd0, 0,  1, 0, 2'd0, 0);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
